// File: rtl/t9990_ram_arb_pkg.sv
// rtl/t9990_ram_arb_pkg.sv - shared types and encodings for the VRAM slot arbiter
package t9990_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_COMPLETE
  } state_t;

  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_32 = 2'd2;

  // Wide enough for 16 clients plus the refresh code.
  localparam int AGENT_W = 5;
  typedef logic [AGENT_W-1:0] agent_t;

  // Codes 0..n_clients-1 select a client; the code after the last client selects refresh.
  function automatic agent_t rfsh_agent(input int n_clients);
    return agent_t'(n_clients);
  endfunction

endpackage

// File: rtl/t9990_ram_arb_if.sv
// rtl/t9990_ram_arb_if.sv - client request bus and RAM slot bus bundled for the arbiter
interface t9990_ram_arb_if #(
  parameter int N_CLIENTS = 6,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 32
);

  logic                    RAM_REQ;
  logic                    RAM_ACK_n;
  logic                    RAM_OE_n;
  logic                    RAM_WE_n;
  logic                    RAM_RFSH_n;
  logic [ADDR_W-1:0]       RAM_ADDR;
  logic [DATA_W-1:0]       RAM_DIN;
  logic [1:0]              RAM_DIN_SIZE;
  logic [DATA_W-1:0]       RAM_DOUT;
  logic [N_CLIENTS-1:0]    CL_REQ;
  logic [N_CLIENTS-1:0]    CL_WE;
  logic [N_CLIENTS*ADDR_W-1:0] CL_ADDR;
  logic [N_CLIENTS*DATA_W-1:0] CL_DIN;
  logic [N_CLIENTS*2-1:0]  CL_SIZE;
  logic [N_CLIENTS-1:0]    CL_ACK;
  logic [DATA_W-1:0]       CL_DOUT;
  logic                    BUSY;

  modport master (
    input  RAM_REQ, RAM_ACK_n, RAM_DOUT, CL_REQ, CL_WE, CL_ADDR, CL_DIN, CL_SIZE,
    output RAM_OE_n, RAM_WE_n, RAM_RFSH_n, RAM_ADDR, RAM_DIN, RAM_DIN_SIZE,
           CL_ACK, CL_DOUT, BUSY
  );

  modport slave (
    output RAM_REQ, RAM_ACK_n, RAM_DOUT, CL_REQ, CL_WE, CL_ADDR, CL_DIN, CL_SIZE,
    input  RAM_OE_n, RAM_WE_n, RAM_RFSH_n, RAM_ADDR, RAM_DIN, RAM_DIN_SIZE,
           CL_ACK, CL_DOUT, BUSY
  );

endinterface

// File: rtl/t9990_ram_arb_rr_pick.sv
// rtl/t9990_ram_arb_rr_pick.sv - round-robin first-set search over [LO,HI] with its pointer
module t9990_rr_pick
  import t9990_ram_arb_pkg::*;
#(
  parameter int LO = 4,
  parameter int HI = 5
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic [HI-LO:0]    req,
  input  logic              adv,
  input  agent_t            adv_agent,
  output logic              found,
  output agent_t            pick
);

  localparam int SPAN = HI - LO + 1;

  agent_t ptr;

  // Outer loop is the distance from the pointer, so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    pick  = agent_t'(LO);
    for (int k = 0; k < SPAN; k++) begin
      for (int j = LO; j <= HI; j++) begin
        if (!found && req[j-LO] &&
            ((int'(ptr) + k == j) || (int'(ptr) + k - SPAN == j))) begin
          found = 1'b1;
          pick  = agent_t'(j);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      ptr <= agent_t'(LO);
    end else if (adv) begin
      ptr <= (adv_agent == agent_t'(HI)) ? agent_t'(LO) : adv_agent + agent_t'(1);
    end
  end

endmodule

// File: rtl/t9990_ram_arb.sv
// rtl/t9990_ram_arb.sv - VRAM slot arbiter: fixed-priority display, round-robin others, refresh
module t9990_ram_arb
  import t9990_ram_arb_pkg::*;
#(
  parameter int N_CLIENTS      = 6,
  parameter int N_DISPLAY      = 4,
  parameter int ADDR_W         = 19,
  parameter int DATA_W         = 32,
  parameter int RFSH_INTERVAL  = 256,
  parameter int RFSH_MAX_DEFER = 8
) (
  input  logic           CLK,
  input  logic           RESET_n,
  t9990_ram_arb_if.master bus
);

  localparam agent_t AG_RFSH = rfsh_agent(N_CLIENTS);
  localparam int CNT_W = (RFSH_INTERVAL > 1) ? $clog2(RFSH_INTERVAL) : 1;
  localparam int DEF_W = $clog2(RFSH_MAX_DEFER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RFSH_INTERVAL - 1);
  localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(RFSH_MAX_DEFER);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  rfsh_cnt;
  logic              rfsh_pend;
  logic [DEF_W-1:0]  rfsh_defer;

  agent_t            cur_agent;
  logic              cur_we;
  logic              cur_rfsh;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q;
  logic [1:0]        size_q;

  logic              disp_found;
  agent_t            disp_agent;
  logic              rr_found;
  agent_t            rr_agent;
  logic              win_valid;
  logic              win_rfsh;
  logic              win_rr;
  agent_t            win_agent;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [1:0]        sel_size;
  logic              sel_we;

  logic              grant;
  logic              ack_seen;
  logic              rfsh_wrap;
  logic              rfsh_done;
  logic              rfsh_urgent;

  logic              oe_n;
  logic              we_n;
  logic              rfsh_n;
  logic              busy;
  logic [N_CLIENTS-1:0] cl_ack;

  // Scan downward so the last hit, the lowest index, sticks.
  always_comb begin
    disp_found = 1'b0;
    disp_agent = '0;
    for (int i = N_DISPLAY - 1; i >= 0; i--) begin
      if (bus.CL_REQ[i]) begin
        disp_found = 1'b1;
        disp_agent = agent_t'(i);
      end
    end
  end

  t9990_rr_pick #(
    .LO (N_DISPLAY),
    .HI (N_CLIENTS - 1)
  ) u_rr_pick (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .req       (bus.CL_REQ[N_CLIENTS-1:N_DISPLAY]),
    .adv       (grant && win_rr),
    .adv_agent (win_agent),
    .found     (rr_found),
    .pick      (rr_agent)
  );

  assign rfsh_urgent = rfsh_pend && (rfsh_defer >= DEF_MAX);

  always_comb begin
    win_valid = 1'b1;
    win_rfsh  = 1'b0;
    win_rr    = 1'b0;
    win_agent = AG_RFSH;
    if (rfsh_urgent) begin
      win_rfsh = 1'b1;
    end else if (disp_found) begin
      win_agent = disp_agent;
    end else if (rfsh_pend) begin
      win_rfsh = 1'b1;
    end else if (rr_found) begin
      win_rr    = 1'b1;
      win_agent = rr_agent;
    end else begin
      win_valid = 1'b0;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_size = SIZE_8;
    sel_we   = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!win_rfsh && win_agent == agent_t'(i)) begin
        sel_addr = bus.CL_ADDR[i*ADDR_W +: ADDR_W];
        sel_din  = bus.CL_DIN[i*DATA_W +: DATA_W];
        sel_size = bus.CL_SIZE[i*2 +: 2];
        sel_we   = bus.CL_WE[i];
      end
    end
  end

  assign grant     = (state == ST_IDLE) && bus.RAM_REQ && win_valid;
  assign ack_seen  = (state == ST_ACCESS) && !bus.RAM_ACK_n;
  assign rfsh_wrap = bus.RAM_REQ && (rfsh_cnt == CNT_LAST);
  assign rfsh_done = ack_seen && cur_rfsh;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (grant) state_nxt = ST_ACCESS;
      ST_ACCESS:   if (!bus.RAM_ACK_n) state_nxt = ST_COMPLETE;
      ST_COMPLETE: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oe_n   = 1'b1;
    we_n   = 1'b1;
    rfsh_n = 1'b1;
    busy   = 1'b0;
    cl_ack = '0;
    case (state)
      ST_ACCESS: begin
        busy = 1'b1;
        if (cur_rfsh)    rfsh_n = 1'b0;
        else if (cur_we) we_n   = 1'b0;
        else             oe_n   = 1'b0;
      end
      ST_COMPLETE: begin
        for (int i = 0; i < N_CLIENTS; i++) begin
          cl_ack[i] = !cur_rfsh && (cur_agent == agent_t'(i));
        end
      end
      default: ;
    endcase
  end

  // Refresh keeps the previous address and data on the bus.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      cur_agent <= '0;
      cur_we    <= 1'b0;
      cur_rfsh  <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      size_q    <= SIZE_8;
      dout_q    <= '0;
    end else begin
      if (grant) begin
        cur_agent <= win_agent;
        cur_rfsh  <= win_rfsh;
        cur_we    <= sel_we;
        if (!win_rfsh) begin
          addr_q <= sel_addr;
          din_q  <= sel_din;
          size_q <= sel_size;
        end
      end
      if (ack_seen && !cur_rfsh && !cur_we) begin
        dout_q <= bus.RAM_DOUT;
      end
    end
  end

  // A wrap on the same edge a refresh finishes re-arms pending.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      rfsh_cnt   <= '0;
      rfsh_pend  <= 1'b0;
      rfsh_defer <= '0;
    end else begin
      if (bus.RAM_REQ) begin
        rfsh_cnt <= rfsh_wrap ? '0 : rfsh_cnt + 1'b1;
      end
      if (rfsh_wrap) begin
        rfsh_pend <= 1'b1;
      end else if (rfsh_done) begin
        rfsh_pend <= 1'b0;
      end
      if (rfsh_done) begin
        rfsh_defer <= '0;
      end else if (grant && !win_rfsh && rfsh_pend && (rfsh_defer < DEF_MAX)) begin
        rfsh_defer <= rfsh_defer + 1'b1;
      end
    end
  end

  assign bus.RAM_OE_n     = oe_n;
  assign bus.RAM_WE_n     = we_n;
  assign bus.RAM_RFSH_n   = rfsh_n;
  assign bus.RAM_ADDR     = addr_q;
  assign bus.RAM_DIN      = din_q;
  assign bus.RAM_DIN_SIZE = size_q;
  assign bus.CL_ACK       = cl_ack;
  assign bus.CL_DOUT      = dout_q;
  assign bus.BUSY         = busy;

endmodule
